rsp_s2_prep_mc_fifo: RTL and testbench
======================================

# rsp_s2_prep_mc_fifo

Multi-channel first-word-fall-through FIFO for the RSP stage-2 prep path, successor to the single-channel prep FIFO. It holds CH independent queues of DEPTH words each. A single shared write port is steered by a channel index, and each channel has its own pop and FWFT head output. Over the single-channel part it adds:
- a run-time almost-full threshold;
- push-through-on-pop when full;
- sticky overflow/underflow error flags per channel.

## Interface
Parameters:
- WIDTH, 128, data word width
- CH, 4, number of channels (≥1)
- DEPTH, 16, words per channel (≥2, need not be a power of two)
- DEPTH_BITS, $clog2(DEPTH), pointer width
- CH_BITS, (CH>1 ? $clog2(CH) : 1), channel index width

Ports:
- clk  in  1  clock, single domain
- rst_n  in  1  reset, asynchronous, active-low
- push  in  1  write strobe
- push_ch  in  CH_BITS  target channel of push; values ≥ CH are ignored
- din  in  WIDTH  write data
- pop  in  CH  per-channel read strobe
- dout  out  CH*WIDTH  head word of channel c on [c*WIDTH +: WIDTH]
- empty  out  CH  channel holds 0 words
- full  out  CH  channel holds DEPTH words
- afull  out  CH  channel count ≥ afull_thresh
- afull_thresh  in  DEPTH_BITS+1  almost-full level, shared by all channels; quasi-static
- word_counter  out  CH*(DEPTH_BITS+1)  per-channel occupancy on [c*(DEPTH_BITS+1) +: DEPTH_BITS+1]
- ovf_err  out  CH  sticky: push dropped on a full channel
- udf_err  out  CH  sticky: pop issued on an empty channel
- err_clr  in  1  clears all ovf_err/udf_err bits

## Operation
- Per channel: wr_ptr, rd_ptr (0..DEPTH-1) and count (0..DEPTH). Each pointer wraps explicitly from DEPTH-1 to 0; power-of-two rollover is not relied on.
- Pop on channel c is accepted when count_c > 0. Pop on an empty channel is ignored and sets udf_err[c].
- Push to channel c = push_ch is accepted when count_c < DEPTH, or when count_c == DEPTH and pop[c] is accepted in the same cycle.
  - A push rejected on a full channel is dropped and sets ovf_err[c].
  - A push with push_ch ≥ CH is dropped silently and sets no flag.
- A push and a pop on the same empty channel in one cycle: the pop sets udf_err; the push is accepted and count becomes 1.
- Count update per channel: +1 for an accepted push only, −1 for an accepted pop only, unchanged for both or neither.
- All flags are derived from count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - afull = (count ≥ afull_thresh), so thresh 0 gives afull constantly 1, and thresh > DEPTH gives afull never set.
- Errors: set has priority over err_clr in the same cycle. Flags clear only via err_clr or reset.
- dout[c] = storage[c][rd_ptr_c], a combinational read of flop storage. Its value is don't-care while empty[c]=1.
- Storage is not reset.

## Timing
- Reset (async assert) values:
  - all pointers and counts 0
  - empty all 1; full 0
  - afull = (afull_thresh==0)
  - word_counter 0; ovf_err and udf_err 0
  - dout don't-care
- Reset deassertion is synchronised externally. There is no reset-mid-operation recovery beyond a full clear; contents are lost.
- Push accepted at edge N: empty falls, word_counter increments, and dout carries the word after edge N. This is zero-cycle fall-through visibility in cycle N+1.
- Pop accepted at edge N: dout shows the next word (or don't-care if now empty) after edge N.
- Flags and counters are registered or derived from registered count; none depend combinationally on push/pop.
- The error flag is visible in the cycle after the offending request.
- Throughput: one push (any channel) plus one pop per channel per cycle.

## Structure
- Shared package rsp_s2_prep_pkg: default WIDTH/CH/DEPTH constants and a function for safe clog2 (min 1).
- Sub-module rsp_s2_prep_mc_fifo_ch: one channel (storage, pointers, count, flags, error bits). It takes a decoded push_en, pop and err_clr and is instantiated CH times via generate.
- The top level holds the push_ch decode and output bus packing only.

## Test plan
- Reset with afull_thresh=0, then afull_thresh=12 → empty=all 1, full=0, counters 0, errors 0; afull all 1 (thresh 0) then all 0 (thresh 12).
- Push 0xA1..0xA3 to ch2 on consecutive cycles → after 3rd edge word_counter[2]=3, dout[2]=0xA1. Other channels stay empty.
- Pop ch2 three times → dout[2] shows 0xA2, then 0xA3, then empty[2]=1.
- Fill ch0 to DEPTH=16, push again → ovf_err[0]=1 and count stays 16. Push with pop same cycle → accepted, count 16, and the new word emerges after 15 further pops.
- Pop empty ch1 together with push to ch1 → udf_err[1]=1, count 1. Assert err_clr with a new udf event the same cycle → flag stays 1; clear alone → 0.
- Wrap test with DEPTH=6: 20 interleaved push/pop of incrementing data on all channels plus push_ch=CH (dropped) → in-order data per channel, no flags.

Source files
------------

// File: rtl/rsp_s2_prep_mc_fifo_pkg.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_pkg
// Shared constants for the RSP stage-2 prep FIFOs.
//   DEF_WIDTH / DEF_CH / DEF_DEPTH : default word width, channel count, depth
//   safe_clog2(n)                  : ceil(log2(n)), never smaller than 1, so
//                                    a single-channel build keeps a 1-bit index
// ----------------------------------------------------------------------------
package rsp_s2_prep_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_CH    = 4;
    localparam int DEF_DEPTH = 16;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsp_s2_prep_mc_fifo_if.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_mc_fifo_if
// Bundles the shared write port, the per-channel pop strobes and all status
// outputs of the multi-channel prep FIFO.
//   master : producer/consumer side (drives push, push_ch, din, pop,
//            afull_thresh, err_clr; observes dout and all status)
//   slave  : the FIFO itself
// Per-channel buses are packed with channel c on [c*W +: W].
// ----------------------------------------------------------------------------
interface rsp_s2_prep_mc_fifo_if
    import rsp_s2_prep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CH         = DEF_CH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEPTH_BITS = safe_clog2(DEPTH),
    parameter int CH_BITS    = safe_clog2(CH)
);

    logic                          push;
    logic [CH_BITS-1:0]            push_ch;
    logic [WIDTH-1:0]              din;
    logic [CH-1:0]                 pop;
    logic [DEPTH_BITS:0]           afull_thresh;
    logic                          err_clr;

    logic [CH*WIDTH-1:0]           dout;
    logic [CH-1:0]                 empty;
    logic [CH-1:0]                 full;
    logic [CH-1:0]                 afull;
    logic [CH*(DEPTH_BITS+1)-1:0]  word_counter;
    logic [CH-1:0]                 ovf_err;
    logic [CH-1:0]                 udf_err;

    modport master (
        output push, push_ch, din, pop, afull_thresh, err_clr,
        input  dout, empty, full, afull, word_counter, ovf_err, udf_err
    );

    modport slave (
        input  push, push_ch, din, pop, afull_thresh, err_clr,
        output dout, empty, full, afull, word_counter, ovf_err, udf_err
    );

endinterface

// File: rtl/rsp_s2_prep_mc_fifo_ch.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_mc_fifo_ch
// One first-word-fall-through channel of the multi-channel prep FIFO.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_en_i, din_i : decoded write strobe for this channel and its data
//   pop_i            : read strobe
//   err_clr_i        : clears the sticky error bits (a new set wins)
//   afull_thresh_i   : almost-full level
//   dout_o           : head word (combinational read, don't-care when empty)
//   empty_o, full_o, afull_o, count_o : occupancy status, from registered count
//   ovf_err_o, udf_err_o              : sticky overflow / underflow
// ----------------------------------------------------------------------------
module rsp_s2_prep_mc_fifo_ch
    import rsp_s2_prep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEPTH_BITS = safe_clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_en_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    input  logic                  err_clr_i,
    input  logic [DEPTH_BITS:0]   afull_thresh_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  afull_o,
    output logic [DEPTH_BITS:0]   count_o,
    output logic                  ovf_err_o,
    output logic                  udf_err_o
);

    localparam logic [DEPTH_BITS:0]   DEPTH_C  = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] LAST_PTR = DEPTH_BITS'(DEPTH-1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  is_empty, is_full, pop_acc, push_acc;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign pop_acc  = pop_i && !is_empty;
    // A full channel still takes a push when its head leaves in the same cycle.
    assign push_acc = push_en_i && (!is_full || pop_acc);

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    // Error bits apply the clear first so a same-cycle set overrides it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end
        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (push_en_i && !push_acc) begin
            ovf_d = 1'b1;
        end
        if (pop_i && is_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o    = mem_q[rd_ptr_q];
    assign empty_o   = is_empty;
    assign full_o    = is_full;
    assign afull_o   = (count_q >= afull_thresh_i);
    assign count_o   = count_q;
    assign ovf_err_o = ovf_q;
    assign udf_err_o = udf_q;

endmodule

// File: rtl/rsp_s2_prep_mc_fifo.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_mc_fifo
// CH independent FWFT queues of DEPTH words behind one shared write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of rsp_s2_prep_mc_fifo_if (write port, per-channel
//                pops, packed head words, occupancy flags, sticky errors)
// This level only decodes push_ch and packs per-channel results onto the bus.
// ----------------------------------------------------------------------------
module rsp_s2_prep_mc_fifo
    import rsp_s2_prep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CH         = DEF_CH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEPTH_BITS = safe_clog2(DEPTH),
    parameter int CH_BITS    = safe_clog2(CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rsp_s2_prep_mc_fifo_if.slave   bus
);

    localparam int CW = DEPTH_BITS + 1;

    logic [CH-1:0] push_en;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        // An index at or above CH matches no channel, so such pushes vanish.
        assign push_en[c] = bus.push && (bus.push_ch == CH_BITS'(c));

        rsp_s2_prep_mc_fifo_ch #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .DEPTH_BITS (DEPTH_BITS)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .push_en_i      (push_en[c]),
            .din_i          (bus.din),
            .pop_i          (bus.pop[c]),
            .err_clr_i      (bus.err_clr),
            .afull_thresh_i (bus.afull_thresh),
            .dout_o         (bus.dout[c*WIDTH +: WIDTH]),
            .empty_o        (bus.empty[c]),
            .full_o         (bus.full[c]),
            .afull_o        (bus.afull[c]),
            .count_o        (bus.word_counter[c*CW +: CW]),
            .ovf_err_o      (bus.ovf_err[c]),
            .udf_err_o      (bus.udf_err[c])
        );
    end

endmodule

// File: tb/tb_rsp_s2_prep_mc_fifo.sv
// ----------------------------------------------------------------------------
// tb_rsp_s2_prep_mc_fifo
// Self-checking bench for the multi-channel prep FIFO. The reference model is
// one queue per channel plus sticky error bits; the driver records the
// expected status each cycle and the expected word of every accepted pop, and
// a separate monitor compares the DUT against those records.
// ----------------------------------------------------------------------------
module tb_rsp_s2_prep_mc_fifo;
    import rsp_s2_prep_pkg::*;

    localparam int WIDTH = 32;
    localparam int CH    = 3;
    localparam int DEPTH = 6;
    localparam int DB    = safe_clog2(DEPTH);
    localparam int CHB   = safe_clog2(CH);
    localparam int CW    = DB + 1;

    typedef struct {
        logic [CH-1:0]       empty;
        logic [CH-1:0]       full;
        logic [CH-1:0]       afull;
        logic [CH-1:0]       ovf;
        logic [CH-1:0]       udf;
        logic [CH-1:0]       headValid;
        logic [CH*CW-1:0]    count;
        logic [CH*WIDTH-1:0] head;
    } status_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rsp_s2_prep_mc_fifo_if #(.WIDTH(WIDTH), .CH(CH), .DEPTH(DEPTH)) bus ();

    rsp_s2_prep_mc_fifo #(.WIDTH(WIDTH), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    status_t          statusQ [$];
    logic [WIDTH-1:0] modelQ  [CH][$];
    logic [WIDTH-1:0] popSb   [CH][$];
    logic [CH-1:0]    mOvf;
    logic [CH-1:0]    mUdf;
    int               threshVal;
    int               checks = 0;
    int               fails  = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: record the status the DUT should show now, drive the inputs,
    // then advance the queue model to the state after the coming edge.
    task automatic applyStimulus(input logic doPush, input logic [CHB-1:0] ch,
                                 input logic [WIDTH-1:0] data, input logic [CH-1:0] popV,
                                 input logic clr);
        status_t s;
        int      sz;
        logic    popAcc, hit, pushAcc;
        @(negedge clk);
        bus.afull_thresh = CW'(threshVal);
        for (int c = 0; c < CH; c++) begin
            sz = modelQ[c].size();
            s.empty[c]     = (sz == 0);
            s.full[c]      = (sz == DEPTH);
            s.afull[c]     = (sz >= threshVal);
            s.ovf[c]       = mOvf[c];
            s.udf[c]       = mUdf[c];
            s.headValid[c] = (sz > 0);
            s.count[c*CW +: CW]       = CW'(sz);
            s.head[c*WIDTH +: WIDTH]  = (sz > 0) ? modelQ[c][0] : '0;
        end
        statusQ.push_back(s);
        bus.push    = doPush;
        bus.push_ch = ch;
        bus.din     = data;
        bus.pop     = popV;
        bus.err_clr = clr;
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                popAcc  = popV[c] && (modelQ[c].size() > 0);
                hit     = doPush && (int'(ch) == c);
                pushAcc = hit && ((modelQ[c].size() < DEPTH) || popAcc);
                if (clr) begin
                    mOvf[c] = 1'b0;
                    mUdf[c] = 1'b0;
                end
                if (popV[c] && !popAcc) mUdf[c] = 1'b1;
                if (hit && !pushAcc)    mOvf[c] = 1'b1;
                if (popAcc)  popSb[c].push_back(modelQ[c].pop_front());
                if (pushAcc) modelQ[c].push_back(data);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Monitor: compares recorded status, and for each pop the DUT accepts,
    // the word it presents against the scoreboard entry.
    initial begin : monitor
        status_t s;
        forever begin
            @(negedge clk);
            #2;
            if (statusQ.size() > 0) begin
                s = statusQ.pop_front();
                checkOutput("empty", 128'(bus.empty), 128'(s.empty));
                checkOutput("full", 128'(bus.full), 128'(s.full));
                checkOutput("afull", 128'(bus.afull), 128'(s.afull));
                checkOutput("word_counter", 128'(bus.word_counter), 128'(s.count));
                checkOutput("ovf_err", 128'(bus.ovf_err), 128'(s.ovf));
                checkOutput("udf_err", 128'(bus.udf_err), 128'(s.udf));
                for (int c = 0; c < CH; c++) begin
                    if (s.headValid[c])
                        checkOutput($sformatf("head[%0d]", c), 128'(bus.dout[c*WIDTH +: WIDTH]),
                                    128'(s.head[c*WIDTH +: WIDTH]));
                    if (bus.pop[c] && !bus.empty[c]) begin
                        if (popSb[c].size() == 0) begin
                            checks++;
                            fails++;
                            $display("[TB] FAIL popData[%0d]: DUT accepted a pop, model expected none", c);
                        end else begin
                            checkOutput($sformatf("popData[%0d]", c), 128'(bus.dout[c*WIDTH +: WIDTH]),
                                        128'(popSb[c].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        rst_n            = 1'b1;
        bus.push         = 1'b0;
        bus.push_ch      = '0;
        bus.din          = '0;
        bus.pop          = '0;
        bus.err_clr      = 1'b0;
        bus.afull_thresh = '0;
        mOvf             = '0;
        mUdf             = '0;
        threshVal        = 0;
        #1 rst_n = 1'b0;

        // Reset state under two thresholds.
        idle(2);
        threshVal = 4;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Fall-through on ch2, then drain it.
        applyStimulus(1'b1, 2'd2, 32'hA1, '0, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hA2, '0, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hA3, '0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 3'b100, 1'b0);
        idle(1);

        // Fill ch0, overflow it, push-through on a full pop, then drain.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'd0, 32'hB0 + 32'(i), '0, 1'b0);
        applyStimulus(1'b1, 2'd0, 32'hBF, '0, 1'b0);
        applyStimulus(1'b1, 2'd0, 32'hC0, 3'b001, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 3'b001, 1'b0);
        idle(1);

        // Underflow with simultaneous push, set-beats-clear, then clear alone.
        applyStimulus(1'b1, 2'd1, 32'hD1, 3'b010, 1'b0);
        applyStimulus(1'b0, '0, '0, 3'b010, 1'b0);
        applyStimulus(1'b0, '0, '0, 3'b010, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        idle(1);

        // Out-of-range channel index is dropped without a flag.
        applyStimulus(1'b1, 2'd3, 32'hEE, '0, 1'b0);
        threshVal = DEPTH + 1;
        applyStimulus(1'b1, 2'd1, 32'hE1, '0, 1'b0);
        threshVal = 0;
        idle(1);

        // Randomised traffic including dropped channel 3 and rare clears.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) threshVal = int'($urandom_range(0, DEPTH + 1));
            applyStimulus(($urandom % 4) != 0, CHB'($urandom % 4), $urandom,
                          CH'($urandom) & CH'($urandom), ($urandom % 32) == 0);
        end

        // Drain every channel completely.
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, '0, 3'b111, 1'b0);
        idle(2);

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
